// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_decoder
// Description : Locks onto incoming active-low HSYNC/VSYNC (640x480@60) and
//               rebuilds pixel X/Y plus a visible-area strobe.
//               Optional macro VGA_RX_SYNCHRONIZER_EN adds a 2-flop input
//               synchronizer for asynchronous sources.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_decoder #(
    parameter int HorizontalFrontPorch = 16,
    parameter int HSYNCPulse           = 96,
    parameter int HorizontalBackPorch  = 48,
    parameter int VisiblePixels        = 640,
    parameter int VerticalFrontPorch   = 10,
    parameter int VSYNCPulse           = 2,
    parameter int VerticalBackPorch    = 33,
    parameter int VisibleLines         = 480,
    parameter int LockLines            = 4
) (
    input  logic       Pixelclock,
    input  logic       reset,
    input  logic       enable,
    input  logic       HSYNC_in,
    input  logic       VSYNC_in,
    output logic [9:0] X,
    output logic [9:0] Y,
    output logic       visible,
    output logic       locked,
    output logic       sync_error,
    output logic [9:0] line_length
);

    localparam logic [9:0] HSYNC_W = 10'(HSYNCPulse);
    localparam logic [9:0] H_TOTAL = 10'(HorizontalFrontPorch + HSYNCPulse
                                         + HorizontalBackPorch + VisiblePixels);
    localparam logic [9:0] HOFF    = 10'(HSYNCPulse + HorizontalBackPorch);
    localparam logic [9:0] HEND    = 10'(HSYNCPulse + HorizontalBackPorch + VisiblePixels);
    localparam logic [9:0] V_TOTAL = 10'(VerticalFrontPorch + VSYNCPulse
                                         + VerticalBackPorch + VisibleLines);
    localparam logic [9:0] VOFF    = 10'(VSYNCPulse + VerticalBackPorch);
    localparam logic [9:0] VEND    = 10'(VSYNCPulse + VerticalBackPorch + VisibleLines);
    localparam logic [9:0] CNT_MAX = 10'h3FF;
    localparam int         GW      = $clog2(LockLines + 1);
    localparam logic [GW-1:0] LOCK_N  = GW'(LockLines);
    localparam logic [GW-1:0] LOCK_M1 = GW'(LockLines - 1);

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_MEASURE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    logic hs_in;
    logic vs_in;

`ifdef VGA_RX_SYNCHRONIZER_EN
    logic [1:0] hs_sync_q;
    logic [1:0] vs_sync_q;

    always_ff @(posedge Pixelclock) begin
        if (reset) begin
            hs_sync_q <= 2'b11;
            vs_sync_q <= 2'b11;
        end else if (enable) begin
            hs_sync_q <= {hs_sync_q[0], HSYNC_in};
            vs_sync_q <= {vs_sync_q[0], VSYNC_in};
        end
    end

    assign hs_in = hs_sync_q[1];
    assign vs_in = vs_sync_q[1];
`else
    assign hs_in = HSYNC_in;
    assign vs_in = VSYNC_in;
`endif

    logic        h_q, h_prev_q, v_q, v_prev_q;
    logic        hfall_q, hrise_q, vfall_q;
    state_t      state_q, state_d;
    logic [9:0]  hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic [9:0]  pw_q, pw_d;
    logic [9:0]  line_len_q, line_len_d;
    logic [GW-1:0] good_cnt_q, good_cnt_d;
    logic        vpend_q, vpend_d;
    logic        frame_seen_q, frame_seen_d;
    logic        err_q, err_d;
    logic        locked_q;
    logic        vis_q, vis_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [9:0]  hc_plus1;
    logic        line_good;
    logic        hvis, vvis;

    always_comb begin
        // Saturating increment doubles as the measured period on hfall.
        hc_plus1     = (hcount_q == CNT_MAX) ? CNT_MAX : hcount_q + 10'd1;
        line_good    = (hc_plus1 == H_TOTAL) && (pw_q == HSYNC_W);
        hcount_d     = hfall_q ? 10'd0 : hc_plus1;
        pw_d         = hrise_q ? hc_plus1 : pw_q;
        line_len_d   = hfall_q ? hc_plus1 : line_len_q;
        vpend_d      = vfall_q | (vpend_q & ~hfall_q);
        vcount_d     = vcount_q;
        if (hfall_q) begin
            if (vpend_q)
                vcount_d = 10'd0;
            else if (vcount_q != CNT_MAX)
                vcount_d = vcount_q + 10'd1;
        end
        frame_seen_d = frame_seen_q | (hfall_q & vpend_q);
        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        err_d        = 1'b0;

        case (state_q)
            S_SEARCH: begin
                frame_seen_d = 1'b0;
                if (hfall_q) begin
                    state_d    = S_MEASURE;
                    good_cnt_d = '0;
                end
            end
            S_MEASURE: begin
                if (hfall_q) begin
                    if (line_good) begin
                        if (good_cnt_q != LOCK_N)
                            good_cnt_d = good_cnt_q + 1'b1;
                        if (frame_seen_q && (good_cnt_q >= LOCK_M1))
                            state_d = S_LOCKED;
                    end else begin
                        good_cnt_d = '0;
                    end
                end else if (hcount_d == CNT_MAX) begin
                    state_d = S_SEARCH;
                end
            end
            S_LOCKED: begin
                if ((hfall_q && !line_good) || (hcount_d == CNT_MAX)) begin
                    err_d   = 1'b1;
                    state_d = S_SEARCH;
                end
            end
            default: state_d = S_SEARCH;
        endcase

        hvis  = (hcount_q >= HOFF) && (hcount_q < HEND);
        vvis  = (vcount_q >= VOFF) && (vcount_q < VEND) && (vcount_q < V_TOTAL);
        vis_d = (state_q == S_LOCKED) && hvis && vvis;
        x_d   = vis_d ? hcount_q - HOFF : 10'd0;
        y_d   = vis_d ? vcount_q - VOFF : 10'd0;
    end

    always_ff @(posedge Pixelclock) begin
        if (reset) begin
            h_q          <= 1'b1;
            h_prev_q     <= 1'b1;
            v_q          <= 1'b1;
            v_prev_q     <= 1'b1;
            hfall_q      <= 1'b0;
            hrise_q      <= 1'b0;
            vfall_q      <= 1'b0;
            state_q      <= S_SEARCH;
            hcount_q     <= 10'd0;
            vcount_q     <= 10'd0;
            pw_q         <= 10'd0;
            line_len_q   <= 10'd0;
            good_cnt_q   <= '0;
            vpend_q      <= 1'b0;
            frame_seen_q <= 1'b0;
            err_q        <= 1'b0;
            locked_q     <= 1'b0;
            vis_q        <= 1'b0;
            x_q          <= 10'd0;
            y_q          <= 10'd0;
        end else if (enable) begin
            h_q          <= hs_in;
            h_prev_q     <= h_q;
            v_q          <= vs_in;
            v_prev_q     <= v_q;
            hfall_q      <= h_prev_q & ~h_q;
            hrise_q      <= ~h_prev_q & h_q;
            vfall_q      <= v_prev_q & ~v_q;
            state_q      <= state_d;
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            pw_q         <= pw_d;
            line_len_q   <= line_len_d;
            good_cnt_q   <= good_cnt_d;
            vpend_q      <= vpend_d;
            frame_seen_q <= frame_seen_d;
            err_q        <= err_d;
            locked_q     <= (state_d == S_LOCKED);
            vis_q        <= vis_d;
            x_q          <= x_d;
            y_q          <= y_d;
        end
    end

    assign X           = x_q;
    assign Y           = y_q;
    assign visible     = vis_q;
    assign locked      = locked_q;
    assign sync_error  = err_q;
    assign line_length = line_len_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_decoder
// Description : Directed bench for vga_sync_decoder with a pixel scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_decoder;

    localparam int HOFF = 144;
`ifdef VGA_RX_SYNCHRONIZER_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       hs = 1'b1;
    logic       vs = 1'b1;
    logic [9:0] X, Y, line_length;
    logic       visible, locked, sync_error;

    int   checks = 0;
    int   errors = 0;
    int   err_pulses = 0;
    logic en_at_edge = 1'b0;
    bit   sb_en = 1'b0;
    logic [19:0] sb_q[$];

    always #5 clk = ~clk;

    // Short vertical geometry keeps whole frames inside the cycle budget.
    vga_sync_decoder #(
        .VerticalFrontPorch (2),
        .VSYNCPulse         (2),
        .VerticalBackPorch  (2),
        .VisibleLines       (6)
    ) dut (
        .Pixelclock  (clk),
        .reset       (reset),
        .enable      (enable),
        .HSYNC_in    (hs),
        .VSYNC_in    (vs),
        .X           (X),
        .Y           (Y),
        .visible     (visible),
        .locked      (locked),
        .sync_error  (sync_error),
        .line_length (line_length)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) en_at_edge <= enable;

    always @(negedge clk) begin
        if (sync_error === 1'b1) err_pulses <= err_pulses + 1;
    end

    always @(negedge clk) begin : mon
        logic [19:0] e;
        if (sb_en && en_at_edge && visible === 1'b1) begin
            check("sb_nonempty", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("pixel_xy", {12'd0, X, Y}, {12'd0, e});
            end
        end else if (sb_en && visible === 1'b0) begin
            check("xy_zero_outside", {12'd0, X, Y}, 0);
        end
    end

    // One line of source timing; expected pixels are queued when it starts.
    task automatic drive_line(input int period, input int width, input logic vsv,
                              input int exp_y, input int pause_at);
        logic [9:0] xh;
        if (exp_y >= 0)
            for (int x = 0; x < 640; x++) sb_q.push_back({10'(x), 10'(exp_y)});
        for (int i = 0; i < period; i++) begin
            hs = (i < width) ? 1'b0 : 1'b1;
            vs = vsv;
            if (i == pause_at) begin
                xh = X;
                enable = 1'b0;
                repeat (50) @(negedge clk);
                check("pause_x_frozen", {22'd0, X}, {22'd0, xh});
                check("pause_vis_held", {31'd0, visible}, 1);
                check("pause_locked_held", {31'd0, locked}, 1);
                enable = 1'b1;
            end
            @(negedge clk);
            if (exp_y >= 0 && pause_at < 0) begin
                if (i == HOFF + 2 + LAT) check("first_vis_early", {31'd0, visible}, 0);
                if (i == HOFF + 3 + LAT) begin
                    check("first_vis", {31'd0, visible}, 1);
                    check("first_x", {22'd0, X}, 0);
                end
            end
        end
    endtask

    initial begin
        bit hit;
        repeat (3) @(negedge clk);
        check("rst_x", {22'd0, X}, 0);
        check("rst_y", {22'd0, Y}, 0);
        check("rst_visible", {31'd0, visible}, 0);
        check("rst_locked", {31'd0, locked}, 0);
        check("rst_sync_error", {31'd0, sync_error}, 0);
        check("rst_line_length", {22'd0, line_length}, 0);
        reset = 1'b0;
        sb_en = 1'b1;

        // Two nominal frames: lock on line 4 of the first frame.
        for (int f = 0; f < 2; f++) begin
            for (int l = 0; l < 12; l++) begin
                drive_line(800, 96, (l < 2) ? 1'b0 : 1'b1, (l >= 5 && l <= 10) ? l - 5 : -1, -1);
                if (f == 0 && l == 3) check("lock_not_yet", {31'd0, locked}, 0);
                if (f == 0 && l == 4) check("lock_rise", {31'd0, locked}, 1);
            end
        end
        check("nominal_line_length", {22'd0, line_length}, 800);
        check("sb_drained_nominal", sb_q.size(), 0);
        check("no_err_nominal", err_pulses, 0);

        // Long line while locked.
        drive_line(801, 96, 1'b1, -1, -1);
        drive_line(800, 96, 1'b1, -1, -1);
        check("err_single_pulse", err_pulses, 1);
        check("err_unlocked", {31'd0, locked}, 0);
        check("err_not_visible", {31'd0, visible}, 0);
        check("long_line_length", {22'd0, line_length}, 801);
        for (int l = 0; l < 5; l++) begin
            drive_line(800, 96, (l < 2) ? 1'b0 : 1'b1, -1, -1);
            if (l == 3) check("relock_not_yet", {31'd0, locked}, 0);
        end
        check("relock", {31'd0, locked}, 1);
        check("relock_no_err", err_pulses, 1);

        // HSYNC stuck high while locked.
        drive_line(1100, 0, 1'b1, -1, -1);
        check("stuck_err", err_pulses, 2);
        check("stuck_unlocked", {31'd0, locked}, 0);
        check("stuck_x", {22'd0, X}, 0);
        check("stuck_y", {22'd0, Y}, 0);

        // Narrow HSYNC never locks and never errors.
        for (int l = 0; l < 7; l++) drive_line(800, 95, (l < 2) ? 1'b0 : 1'b1, -1, -1);
        check("narrow_no_lock", {31'd0, locked}, 0);
        check("narrow_no_err", err_pulses, 2);
        check("narrow_line_length", {22'd0, line_length}, 800);

        // Relock, then a clock-enable pause in the first visible line.
        for (int l = 0; l < 5; l++) drive_line(800, 96, (l < 2) ? 1'b0 : 1'b1, -1, -1);
        check("lock_before_pause", {31'd0, locked}, 1);
        drive_line(800, 96, 1'b1, 0, 400);
        check("sb_drained_pause", sb_q.size(), 0);

        // Reset in the middle of the next visible line.
        sb_en = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 800; i++) begin
            hs = (i < 96) ? 1'b0 : 1'b1;
            vs = 1'b1;
            @(negedge clk);
            if (visible === 1'b1 && X === 10'd300) begin
                hit = 1'b1;
                break;
            end
        end
        check("reached_x300", {31'd0, hit}, 1);
        check("y_at_x300", {22'd0, Y}, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_x", {22'd0, X}, 0);
        check("mid_rst_y", {22'd0, Y}, 0);
        check("mid_rst_visible", {31'd0, visible}, 0);
        check("mid_rst_locked", {31'd0, locked}, 0);
        check("mid_rst_sync_error", {31'd0, sync_error}, 0);
        check("mid_rst_line_length", {22'd0, line_length}, 0);
        reset = 1'b0;
        hs = 1'b1;
        repeat (20) @(negedge clk);
        hs = 1'b0;
        repeat (96) @(negedge clk);
        hs = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_line_length", {22'd0, line_length}, 23 + LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
